// File: rtl/console_uart_tx.sv
// Console UART transmitter: byte FIFO feeding an 8N1 serial framer.
// Console writes are queued, then sent LSB first at CLKS_PER_BIT clocks per bit.
//
// Ports:
//   clk           - single clock, all state updates on the rising edge
//   reset_n       - asynchronous active-low reset
//   console_we    - one-cycle write strobe from the core
//   console_wdata - write data, only bits [7:0] are transmitted
//   uart_tx       - serial line, idles high, driven straight from a flop
//   busy          - FIFO non-empty or a frame in flight (registered)
//   fifo_full     - FIFO occupancy equals FIFO_DEPTH
//   overflow      - sticky, set when a write was dropped; cleared by reset
module console_uart_tx #(
    parameter int XLEN         = 32,
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            console_we,
    input  logic [XLEN-1:0] console_wdata,
    output logic            uart_tx,
    output logic            busy,
    output logic            fifo_full,
    output logic            overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);

    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [AW:0]   DEPTH_C   = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    // FIFO storage and bookkeeping
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   count_q, count_d;

    // Framer state
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    sh_q, sh_d;

    // Registered outputs
    logic          tx_q, tx_d;
    logic          busy_q, busy_d;
    logic          ovf_q, ovf_d;

    logic          fifo_empty;
    logic          full;
    logic          bit_end;
    logic          pop;
    logic          push;
    logic          drop;
    logic [7:0]    head;

    // Upper data bits are intentionally ignored.
    logic          unused_wdata;
    assign unused_wdata = ^console_wdata[XLEN-1:8];

    assign fifo_empty = (count_q == '0);
    assign full       = (count_q == DEPTH_C);
    assign bit_end    = (cnt_q == BAUD_LAST);
    assign head       = mem_q[rptr_q];

    // Framer next state. A pop happens either from IDLE or at the end of
    // a stop bit, so consecutive frames run with no gap.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        sh_d    = sh_q;
        pop     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    sh_d    = head;
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = START;
                end
            end

            START: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            DATA: begin
                if (bit_end) begin
                    cnt_d = '0;
                    sh_d  = sh_q >> 1;
                    idx_d = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = STOP;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            STOP: begin
                if (bit_end) begin
                    cnt_d = '0;
                    idx_d = '0;
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        sh_d    = head;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase
    end

    // Line level is decoded from the next state so uart_tx is a plain flop.
    always_comb begin
        tx_d = 1'b1;
        unique case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = sh_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    // FIFO control. A full FIFO still accepts a write on a popping edge.
    always_comb begin
        push    = console_we && (!full || pop);
        drop    = console_we && full && !pop;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        ovf_d   = ovf_q | drop;

        if (push) begin
            wptr_d = wptr_q + AW'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + AW'(1);
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    assign busy_d = (state_d != IDLE) || (count_d != '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            sh_q    <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            sh_q    <= sh_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            ovf_q   <= ovf_d;
        end
    end

    // Storage needs no reset: emptiness is tracked by the count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= console_wdata[7:0];
        end
    end

    assign uart_tx   = tx_q;
    assign busy      = busy_q;
    assign fifo_full = full;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_console_uart_tx.sv
// Testbench for console_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=16.
// Directed vector table plus hand-written multi-cycle sequences.
module tb_console_uart_tx;

    logic        clk;
    logic        reset_n;
    logic        console_we;
    logic [31:0] console_wdata;
    logic        uart_tx;
    logic        busy;
    logic        fifo_full;
    logic        overflow;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [31:0] wdata;
        logic [7:0]  exp_byte;
    } vec_t;

    vec_t vecs [5];

    console_uart_tx #(
        .XLEN        (32),
        .CLKS_PER_BIT(4),
        .FIFO_DEPTH  (16)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .console_we   (console_we),
        .console_wdata(console_wdata),
        .uart_tx      (uart_tx),
        .busy         (busy),
        .fifo_full    (fifo_full),
        .overflow     (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        reset_n       = 1'b0;
        console_we    = 1'b0;
        console_wdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_tx", uart_tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_full", fifo_full, 0);
        chk("rst_ovf", overflow, 0);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic write1(input logic [31:0] d);
        console_we    = 1'b1;
        console_wdata = d;
        @(negedge clk);
        console_we    = 1'b0;
        console_wdata = '0;
    endtask

    // Called at the negedge just after the start bit begins; checks all
    // 40 cycles and returns one negedge after the frame ends.
    task automatic check_frame(input string nm, input logic [7:0] b);
        logic [9:0] f;
        f = {1'b1, b, 1'b0};
        for (int k = 0; k < 40; k++) begin
            chk(nm, uart_tx, f[k/4]);
            @(negedge clk);
        end
    endtask

    // Waits for a start bit and samples mid-bit; returns on the first
    // cycle after the stop bit.
    task automatic rx_byte(output logic [7:0] b, output logic ok);
        int t;
        t  = 0;
        b  = '0;
        ok = 1'b1;
        while (uart_tx !== 1'b0 && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (t >= 400) begin
            ok = 1'b0;
            return;
        end
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 2 && uart_tx !== 1'b0) ok = 1'b0;
            if (c >= 6 && c <= 34 && ((c - 6) % 4) == 0)
                b[(c-6)/4] = uart_tx;
            if (c == 38 && uart_tx !== 1'b1) ok = 1'b0;
        end
    endtask

    initial begin
        logic [7:0] rb;
        logic       rok;
        logic       seen_low;

        vecs[0] = '{32'h0000_0041, 8'h41};
        vecs[1] = '{32'hFFFF_FF55, 8'h55};
        vecs[2] = '{32'h0000_00FF, 8'hFF};
        vecs[3] = '{32'h1234_5600, 8'h00};
        vecs[4] = '{32'hDEAD_BE80, 8'h80};

        reset_n       = 1'b0;
        console_we    = 1'b0;
        console_wdata = '0;
        do_reset();

        // Single frames from idle
        for (int i = 0; i < 5; i++) begin
            write1(vecs[i].wdata);
            chk("vec_pre_tx", uart_tx, 1);
            chk("vec_pre_busy", busy, 1);
            @(negedge clk);
            check_frame("vec_frame", vecs[i].exp_byte);
            chk("vec_end_busy", busy, 0);
            chk("vec_end_tx", uart_tx, 1);
        end

        // Back-to-back writes give contiguous frames
        console_we    = 1'b1;
        console_wdata = 32'h41;
        @(negedge clk);
        console_wdata = 32'h42;
        @(negedge clk);
        console_we    = 1'b0;
        console_wdata = '0;
        check_frame("b2b_f1", 8'h41);
        check_frame("b2b_f2", 8'h42);
        chk("b2b_busy", busy, 0);

        // Overflow: 18 writes on consecutive edges
        do_reset();
        fork
            begin
                for (int i = 0; i < 18; i++) begin
                    console_we    = 1'b1;
                    console_wdata = 32'h10 + 32'(i);
                    @(negedge clk);
                    if (i == 0)  chk("ovf_e0_tx", uart_tx, 1);
                    if (i == 1)  chk("ovf_e1_tx", uart_tx, 0);
                    if (i == 15) chk("ovf_e15_full", fifo_full, 0);
                    if (i == 16) chk("ovf_e16_full", fifo_full, 1);
                    if (i == 16) chk("ovf_e16_ovf", overflow, 0);
                end
                console_we    = 1'b0;
                console_wdata = '0;
                chk("ovf_e17_ovf", overflow, 1);
                chk("ovf_e17_full", fifo_full, 1);
            end
            begin
                for (int j = 0; j < 17; j++) begin
                    rx_byte(rb, rok);
                    chk("ovf_rx_ok", 32'(rok), 1);
                    chk("ovf_rx_byte", 32'(rb), 32'h10 + 32'(j));
                end
            end
        join
        seen_low = 1'b0;
        repeat (60) begin
            if (uart_tx !== 1'b1) seen_low = 1'b1;
            @(negedge clk);
        end
        chk("ovf_no_extra", 32'(seen_low), 0);
        chk("ovf_busy", busy, 0);
        chk("ovf_sticky", overflow, 1);

        // Full FIFO accepts a write on the edge the framer pops
        do_reset();
        fork
            begin
                for (int i = 0; i < 17; i++) begin
                    console_we    = 1'b1;
                    console_wdata = 32'h60 + 32'(i);
                    @(negedge clk);
                end
                console_we    = 1'b0;
                console_wdata = '0;
                chk("fwp_e16_full", fifo_full, 1);
                chk("fwp_e16_ovf", overflow, 0);
                repeat (24) @(negedge clk);
                chk("fwp_e40_full", fifo_full, 1);
                console_we    = 1'b1;
                console_wdata = 32'h7F;
                @(negedge clk);
                console_we    = 1'b0;
                console_wdata = '0;
                chk("fwp_e41_full", fifo_full, 1);
                chk("fwp_e41_ovf", overflow, 0);
            end
            begin
                for (int j = 0; j < 18; j++) begin
                    rx_byte(rb, rok);
                    chk("fwp_rx_ok", 32'(rok), 1);
                    chk("fwp_rx_byte", 32'(rb),
                        (j < 17) ? 32'h60 + 32'(j) : 32'h7F);
                end
            end
        join
        chk("fwp_busy", busy, 0);
        chk("fwp_ovf_end", overflow, 0);

        // Reset during data bit 3 aborts the frame at once
        do_reset();
        write1(32'hA5);
        repeat (18) @(negedge clk);
        chk("rmf_bit3_tx", uart_tx, 0);
        chk("rmf_bit3_busy", busy, 1);
        #1 reset_n = 1'b0;
        #1;
        chk("rmf_async_tx", uart_tx, 1);
        chk("rmf_async_busy", busy, 0);
        chk("rmf_async_full", fifo_full, 0);
        chk("rmf_async_ovf", overflow, 0);
        @(negedge clk);
        @(negedge clk);
        chk("rmf_hold_tx", uart_tx, 1);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rmf_rel_tx", uart_tx, 1);
        chk("rmf_rel_busy", busy, 0);
        write1(32'h5A);
        chk("rmf_pre_tx", uart_tx, 1);
        @(negedge clk);
        check_frame("rmf_frame", 8'h5A);
        chk("rmf_end_busy", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
